// File: rtl/keypad_ctrl.sv
// rtl/keypad_ctrl.sv - keypad scan sequencer, frame debouncer and CPU key register/interrupt
module keypad_ctrl #(
  parameter int SCAN_DIV        = 50000,
  parameter int DEBOUNCE_FRAMES = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic       scan_en,
  input  logic       key_press,
  input  logic [3:0] key_data,
  output logic [7:0] key_code,
  output logic       key_int,
  input  logic       int_ack,
  output logic       overrun
);

  localparam int            DW       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [3:0]    DEB_N    = 4'(DEBOUNCE_FRAMES);

  typedef enum logic [1:0] {IDLE, DEB, HELD, REL} state_t;

  logic [DW-1:0] div_cnt;
  logic [1:0]    col_cnt;
  logic          hit;
  logic [3:0]    hit_code;
  state_t        state, state_nxt;
  logic [3:0]    cand, cand_nxt;
  logic [3:0]    stab, stab_nxt;
  logic          report;
  logic          frame_end;
  logic          res_valid;
  logic [3:0]    res_code;

  // Strobe decoded from the divider register so it is glitch-free and exactly one cycle wide.
  assign scan_en   = (div_cnt == DIV_LAST);
  assign frame_end = scan_en && (col_cnt == 2'd3);
  // Frame result includes the last column's own sample when nothing earlier hit.
  assign res_valid = hit || key_press;
  assign res_code  = hit ? hit_code : key_data;

  // Column-step divider: counts 0..SCAN_DIV-1 and wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       div_cnt <= '0;
    else if (scan_en) div_cnt <= '0;
    else              div_cnt <= div_cnt + 1'b1;
  end

  // Column counter and first-press capture within the current frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_cnt  <= 2'd0;
      hit      <= 1'b0;
      hit_code <= 4'h0;
    end else if (scan_en) begin
      col_cnt <= col_cnt + 2'd1;
      if (frame_end) begin
        hit <= 1'b0;
      end else if (!hit && key_press) begin
        hit      <= 1'b1;
        hit_code <= key_data;
      end
    end
  end

  // Debounce state, candidate code and stability count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cand  <= 4'h0;
      stab  <= 4'h0;
    end else begin
      state <= state_nxt;
      cand  <= cand_nxt;
      stab  <= stab_nxt;
    end
  end

  // Debounce transitions, evaluated once per frame end; a report fires when a press is accepted.
  always_comb begin
    state_nxt = state;
    cand_nxt  = cand;
    stab_nxt  = stab;
    report    = 1'b0;
    if (frame_end) begin
      case (state)
        IDLE: begin
          if (res_valid) begin
            cand_nxt = res_code;
            stab_nxt = 4'd1;
            if (DEB_N == 4'd1) begin
              report    = 1'b1;
              state_nxt = HELD;
            end else begin
              state_nxt = DEB;
            end
          end
        end
        DEB: begin
          if (!res_valid) begin
            state_nxt = IDLE;
          end else if (res_code == cand) begin
            stab_nxt = stab + 4'd1;
            if (stab_nxt == DEB_N) begin
              report    = 1'b1;
              state_nxt = HELD;
            end
          end else begin
            cand_nxt = res_code;
            stab_nxt = 4'd1;
          end
        end
        HELD: begin
          if (!res_valid) begin
            stab_nxt  = 4'd1;
            state_nxt = (DEB_N == 4'd1) ? IDLE : REL;
          end
        end
        REL: begin
          if (res_valid) begin
            state_nxt = HELD;
          end else begin
            stab_nxt = stab + 4'd1;
            if (stab_nxt == DEB_N) state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // CPU-visible key register, interrupt and overrun; a report takes priority over an acknowledge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_code <= 8'h00;
      key_int  <= 1'b0;
      overrun  <= 1'b0;
    end else if (report) begin
      key_code <= {4'h0, cand_nxt};
      key_int  <= 1'b1;
      if (int_ack)      overrun <= 1'b0;
      else if (key_int) overrun <= 1'b1;
    end else if (int_ack) begin
      key_int <= 1'b0;
      overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_keypad_ctrl.sv
// tb/tb_keypad_ctrl.sv - vector table, corner sequences and random phases against a frame-level model
module tb_keypad_ctrl;

  localparam int SD = 4;
  localparam int DF = 2;
  localparam int FRAME = 4 * SD;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       scan_en;
  logic       key_press = 1'b0;
  logic [3:0] key_data = 4'h0;
  logic [7:0] key_code;
  logic       key_int;
  logic       int_ack = 1'b0;
  logic       overrun;

  keypad_ctrl #(.SCAN_DIV(SD), .DEBOUNCE_FRAMES(DF)) dut (
    .clk(clk), .rst_n(rst_n), .scan_en(scan_en), .key_press(key_press),
    .key_data(key_data), .key_code(key_code), .key_int(key_int),
    .int_ack(int_ack), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Scanner model: which of the 4 column slots report a press, and their codes.
  logic [3:0]  cur_pv = 4'h0;
  logic [15:0] cur_codes = 16'h0;

  // Reference model: cycle index, frame capture, run length of identical frame results.
  int         m_n;
  bit         m_hit;
  int         m_fcode;
  int         m_last;
  int         m_run;
  bit         m_down;
  bit         m_int;
  logic [7:0] m_code;
  bit         m_ov;

  typedef struct {
    logic [3:0]  pv;
    logic [15:0] codes;
    int          frames;
    bit          ack_first;
    bit          ack_last;
    bit          e_int;
    logic [7:0]  e_code;
    bit          e_ov;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic [3:0] pv, logic [15:0] codes, int fr, bit af, bit al,
                              bit ei, logic [7:0] ec, bit eo);
    vec_t v;
    v.pv = pv; v.codes = codes; v.frames = fr; v.ack_first = af; v.ack_last = al;
    v.e_int = ei; v.e_code = ec; v.e_ov = eo;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_n = 0; m_hit = 0; m_fcode = 0; m_last = -1; m_run = 0; m_down = 0;
    m_int = 0; m_code = 8'h00; m_ov = 0;
  endtask

  task automatic model_step(input bit kp, input logic [3:0] kd, input bit ack);
    int r;
    bit rep;
    rep = 0;
    if (m_n % SD == SD - 1) begin
      if (!m_hit && kp) begin
        m_hit = 1;
        m_fcode = int'(kd);
      end
      if (m_n % FRAME == FRAME - 1) begin
        r = m_hit ? m_fcode : -1;
        m_hit = 0;
        if (r == m_last) m_run++;
        else begin
          m_last = r;
          m_run = 1;
        end
        if (!m_down && r != -1 && m_run == DF) begin
          rep = 1;
          m_down = 1;
        end else if (m_down && r == -1 && m_run == DF) begin
          m_down = 0;
        end
        if (rep) begin
          if (m_int && !ack) m_ov = 1;
          else if (ack) m_ov = 0;
          m_int = 1;
          m_code = 8'(r);
        end
      end
    end
    if (!rep && ack && m_int) begin
      m_int = 0;
      m_ov = 0;
    end
    m_n++;
  endtask

  task automatic check_outputs();
    chk("scan_en", scan_en, (m_n % SD == SD - 1));
    chk("key_int", key_int, m_int);
    chk("key_code", key_code, m_code);
    chk("overrun", overrun, m_ov);
  endtask

  task automatic tick(input bit ack);
    int col;
    col = (m_n / SD) % 4;
    key_press = cur_pv[col];
    key_data = cur_pv[col] ? cur_codes[4*col +: 4] : 4'($urandom_range(0, 15));
    int_ack = ack;
    @(posedge clk);
    model_step(key_press, key_data, ack);
    #1;
    check_outputs();
  endtask

  task automatic run_frames(input int frames, input bit ack_first, input bit ack_last);
    for (int f = 0; f < frames; f++) begin
      for (int c = 0; c < FRAME; c++) begin
        tick((ack_first && f == 0 && c == 0) || (ack_last && f == frames - 1 && c == FRAME - 1));
      end
    end
    int_ack = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    chk("rst scan_en", scan_en, 1'b0);
    chk("rst key_int", key_int, 1'b0);
    chk("rst key_code", key_code, 8'h00);
    chk("rst overrun", overrun, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_clear();
    check_outputs();
  endtask

  initial begin
    #1_000_000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    // pv: slot mask, codes: slot i at [4i+:4]
    tbl.push_back(mk(4'b0000, 16'h0000, 4, 0, 0, 0, 8'h00, 0)); // idle, divider only
    tbl.push_back(mk(4'b1000, 16'h5000, 5, 0, 0, 1, 8'h05, 0)); // clean press of 5
    tbl.push_back(mk(4'b1000, 16'h5000, 2, 1, 0, 0, 8'h05, 0)); // ack, still held
    tbl.push_back(mk(4'b0000, 16'h0000, 2, 0, 0, 0, 8'h05, 0)); // release
    for (int i = 0; i < 3; i++) begin                            // bounce of 7
      tbl.push_back(mk(4'b0010, 16'h0070, 1, 0, 0, 0, 8'h05, 0));
      tbl.push_back(mk(4'b0000, 16'h0000, 1, 0, 0, 0, 8'h05, 0));
    end
    tbl.push_back(mk(4'b0010, 16'h0070, 3, 0, 0, 1, 8'h07, 0)); // steady 7
    tbl.push_back(mk(4'b0000, 16'h0000, 2, 1, 0, 0, 8'h07, 0)); // release + ack
    tbl.push_back(mk(4'b0001, 16'h0001, 2, 0, 0, 1, 8'h01, 0)); // key 1
    tbl.push_back(mk(4'b0000, 16'h0000, 2, 0, 0, 1, 8'h01, 0));
    tbl.push_back(mk(4'b0100, 16'h0B00, 2, 0, 0, 1, 8'h0B, 1)); // key B -> overrun
    tbl.push_back(mk(4'b0000, 16'h0000, 2, 0, 0, 1, 8'h0B, 1));
    tbl.push_back(mk(4'b0000, 16'h0000, 1, 1, 0, 0, 8'h0B, 0)); // ack clears both
    tbl.push_back(mk(4'b0110, 16'h0920, 2, 0, 0, 1, 8'h02, 0)); // 2 and 9 together
    tbl.push_back(mk(4'b0000, 16'h0000, 2, 0, 0, 1, 8'h02, 0));
    tbl.push_back(mk(4'b0110, 16'h0920, 2, 0, 1, 1, 8'h02, 0)); // ack on report cycle

    #1;
    do_reset();

    foreach (tbl[i]) begin
      cur_pv = tbl[i].pv;
      cur_codes = tbl[i].codes;
      run_frames(tbl[i].frames, tbl[i].ack_first, tbl[i].ack_last);
      chk($sformatf("vec%0d key_int", i), key_int, tbl[i].e_int);
      chk($sformatf("vec%0d key_code", i), key_code, tbl[i].e_code);
      chk($sformatf("vec%0d overrun", i), overrun, tbl[i].e_ov);
    end

    // Reset in the middle of debouncing key 0 while an interrupt is pending.
    cur_pv = 4'b0001;
    cur_codes = 16'h0000;
    run_frames(1, 0, 0);
    for (int c = 0; c < FRAME / 2; c++) tick(0);
    do_reset();
    run_frames(1, 0, 0);
    chk("rst_deb one frame key_int", key_int, 1'b0);
    run_frames(1, 0, 0);
    chk("rst_deb two frames key_int", key_int, 1'b1);
    chk("rst_deb two frames key_code", key_code, 8'h00);
    cur_pv = 4'b0000;
    run_frames(2, 1, 0);

    // Random key patterns with sporadic acknowledges.
    for (int p = 0; p < 40; p++) begin
      int fr;
      cur_pv = 4'($urandom_range(0, 15));
      for (int s = 0; s < 4; s++) cur_codes[4*s +: 4] = 4'($urandom_range(0, 11));
      fr = $urandom_range(1, 3);
      for (int c = 0; c < fr * FRAME; c++) tick($urandom_range(0, 19) == 0);
    end
    int_ack = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
